// File: rtl/ram_dp_be_ctrl_pkg.sv
// Shared types, read-during-write policy codes and the byte-merge helper for ram_dp_be_ctrl.
package ram_dp_be_ctrl_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } ram_state_e;

   localparam int unsigned RDW_WRITE_FIRST = 0;
   localparam int unsigned RDW_READ_FIRST  = 1;

   // One byte lane of a byte-enabled write.
   function automatic logic [7:0] be_merge(input logic [7:0] old_byte,
                                           input logic [7:0] new_byte,
                                           input logic       be);
      return be ? new_byte : old_byte;
   endfunction

endpackage

// File: rtl/ram_dp_be_ctrl_if.sv
// Request/response bundle of the dual-port RAM: write port, read port and status flags.
interface ram_dp_be_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
);

   logic                    wr_enb;
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [DATA_WIDTH/8-1:0] wr_be;
   logic                    rd_enb;
   logic [ADDR_WIDTH-1:0]   rd_addr;
   logic [DATA_WIDTH-1:0]   rd_data;
   logic                    rd_valid;
   logic                    rd_err;
   logic                    wr_err;
   logic                    init_busy;

   modport master (
      output wr_enb, wr_addr, wr_data, wr_be, rd_enb, rd_addr,
      input  rd_data, rd_valid, rd_err, wr_err, init_busy
   );

   modport slave (
      input  wr_enb, wr_addr, wr_data, wr_be, rd_enb, rd_addr,
      output rd_data, rd_valid, rd_err, wr_err, init_busy
   );

endinterface

// File: rtl/ram_dp_be_ctrl_rd_pipe.sv
// Read-result pipeline: carries {valid, err, data} through LATENCY register stages.
// Data only advances with a valid beat, so the output holds between beats.
module ram_dp_be_ctrl_rd_pipe #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LATENCY    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic                  in_err,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic                  out_err,
   output logic [DATA_WIDTH-1:0] out_data
);

   logic                  vld_q [LATENCY];
   logic                  err_q [LATENCY];
   logic [DATA_WIDTH-1:0] dat_q [LATENCY];

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q[0] <= 1'b0;
         err_q[0] <= 1'b0;
         dat_q[0] <= '0;
      end else begin
         vld_q[0] <= in_valid;
         err_q[0] <= in_valid & in_err;
         if (in_valid) begin
            dat_q[0] <= in_data;
         end
      end
   end

   for (genvar g = 1; g < LATENCY; g++) begin : g_stage
      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q[g] <= 1'b0;
            err_q[g] <= 1'b0;
            dat_q[g] <= '0;
         end else begin
            vld_q[g] <= vld_q[g-1];
            err_q[g] <= err_q[g-1];
            if (vld_q[g-1]) begin
               dat_q[g] <= dat_q[g-1];
            end
         end
      end
   end

   assign out_valid = vld_q[LATENCY-1];
   assign out_err   = err_q[LATENCY-1];
   assign out_data  = dat_q[LATENCY-1];

endmodule

// File: rtl/ram_dp_be_ctrl.sv
// Simple-dual-port RAM with byte enables, 1/2-cycle read latency, selectable
// read-during-write policy, range error flags and a zero-fill sweep after reset.
module ram_dp_be_ctrl
   import ram_dp_be_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 5,
   parameter int unsigned DEPTH        = 32,
   parameter int unsigned RD_LATENCY   = 1,
   parameter int unsigned RDW_MODE     = 0,
   parameter bit          CLEAR_ON_RST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   ram_dp_be_ctrl_if.slave  bus
);

   localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
   localparam int unsigned LAST      = DEPTH - 1;
   // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
   localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = LAST[ADDR_WIDTH-1:0];

   ram_state_e            state_q;
   logic [ADDR_WIDTH-1:0] cnt_q;
   logic                  busy_q;
   logic                  wr_err_q;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  ready;
   logic                  wr_in_range;
   logic                  rd_in_range;
   logic                  wr_do;
   logic                  rd_acc;
   logic                  rdw_hit;
   logic [DATA_WIDTH-1:0] wr_old;
   logic [DATA_WIDTH-1:0] merged;
   logic [DATA_WIDTH-1:0] rd_old;
   logic [DATA_WIDTH-1:0] rd_word;

   assign ready       = (state_q == READY);
   assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_LIM);
   assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_LIM);
   assign wr_do       = ready & bus.wr_enb & wr_in_range;
   assign rd_acc      = ready & bus.rd_enb;
   assign rdw_hit     = wr_do & rd_in_range & (bus.rd_addr == bus.wr_addr);

   assign wr_old = wr_in_range ? mem_q[bus.wr_addr] : '0;
   assign rd_old = rd_in_range ? mem_q[bus.rd_addr] : '0;

   for (genvar g = 0; g < NUM_BYTES; g++) begin : g_merge
      assign merged[8*g +: 8] = be_merge(wr_old[8*g +: 8], bus.wr_data[8*g +: 8], bus.wr_be[g]);
   end

   // Out-of-range reads yield zero; rdw_hit already implies in range.
   always_comb begin
      rd_word = rd_old;
      if (rdw_hit) begin
         case (RDW_MODE)
            RDW_WRITE_FIRST: rd_word = merged;
            RDW_READ_FIRST:  rd_word = rd_old;
            default:         rd_word = merged;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == CLEAR) begin
            mem_q[cnt_q] <= '0;
         end else if (wr_do) begin
            mem_q[bus.wr_addr] <= merged;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= CLEAR_ON_RST ? CLEAR : READY;
         cnt_q    <= '0;
         busy_q   <= CLEAR_ON_RST;
         wr_err_q <= 1'b0;
      end else begin
         wr_err_q <= ready & bus.wr_enb & ~wr_in_range;
         case (state_q)
            CLEAR: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST_ADDR) begin
                  state_q <= READY;
                  busy_q  <= 1'b0;
               end
            end
            READY: begin
               state_q <= READY;
            end
            default: begin
               state_q <= READY;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.wr_err    = wr_err_q;
   assign bus.init_busy = busy_q;

   ram_dp_be_ctrl_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .LATENCY    (RD_LATENCY)
   ) u_rd_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rd_acc),
      .in_err    (~rd_in_range),
      .in_data   (rd_word),
      .out_valid (bus.rd_valid),
      .out_err   (bus.rd_err),
      .out_data  (bus.rd_data)
   );

endmodule

// File: tb/tb_ram_dp_be_ctrl.sv
// Directed bench: two RAM configurations driven by shared stimulus, checked against hand-computed values.
module tb_ram_dp_be_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_enb;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic        rd_enb;
   logic [4:0]  rd_addr;

   int n_checks = 0;
   int n_errs   = 0;

   always #5 clk = ~clk;

   ram_dp_be_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_a ();
   ram_dp_be_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_b ();

   assign bus_a.wr_enb  = wr_enb;
   assign bus_a.wr_addr = wr_addr;
   assign bus_a.wr_data = wr_data;
   assign bus_a.wr_be   = wr_be;
   assign bus_a.rd_enb  = rd_enb;
   assign bus_a.rd_addr = rd_addr;
   assign bus_b.wr_enb  = wr_enb;
   assign bus_b.wr_addr = wr_addr;
   assign bus_b.wr_data = wr_data;
   assign bus_b.wr_be   = wr_be;
   assign bus_b.rd_enb  = rd_enb;
   assign bus_b.rd_addr = rd_addr;

   // A: full depth, latency 1, write-first.  B: depth 20, latency 2, read-first.
   ram_dp_be_ctrl #(
      .DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(32), .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RST(1'b1)
   ) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   ram_dp_be_ctrl #(
      .DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(20), .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RST(1'b1)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_enb  = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      wr_be   = '0;
      rd_enb  = 1'b0;
      rd_addr = '0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
      wr_enb  = 1'b1;
      wr_addr = a;
      wr_data = d;
      wr_be   = be;
   endtask

   task automatic rd(input logic [4:0] a);
      rd_enb  = 1'b1;
      rd_addr = a;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      repeat (3) tick();
      check("rst_vld_a", {31'd0, bus_a.rd_valid}, 32'd0);
      check("rst_vld_b", {31'd0, bus_b.rd_valid}, 32'd0);
      check("rst_busy_a", {31'd0, bus_a.init_busy}, 32'd1);
      check("rst_busy_b", {31'd0, bus_b.init_busy}, 32'd1);
      check("rst_data_a", bus_a.rd_data, 32'd0);
      check("rst_werr_b", {31'd0, bus_b.wr_err}, 32'd0);

      // Sweep: requests during the sweep must be ignored.
      rst = 1'b0;
      wr(5'd1, 32'hFFFF_FFFF, 4'hF);
      rd(5'd0);
      for (int k = 1; k <= 32; k++) begin
         tick();
         check($sformatf("sweep_busy_a_%0d", k), {31'd0, bus_a.init_busy}, {31'd0, k < 32});
         check($sformatf("sweep_busy_b_%0d", k), {31'd0, bus_b.init_busy}, {31'd0, k < 20});
         check($sformatf("sweep_vld_a_%0d", k), {31'd0, bus_a.rd_valid}, 32'd0);
         check($sformatf("sweep_vld_b_%0d", k), {31'd0, bus_b.rd_valid}, 32'd0);
         check($sformatf("sweep_werr_a_%0d", k), {31'd0, bus_a.wr_err}, 32'd0);
         if (k == 18) idle();
      end

      // All words cleared; B flags addresses 20..31.
      for (int i = 0; i < 32; i++) begin
         rd(i[4:0]);
         tick();
         check($sformatf("clr_vld_a_%0d", i), {31'd0, bus_a.rd_valid}, 32'd1);
         check($sformatf("clr_data_a_%0d", i), bus_a.rd_data, 32'd0);
         if (i > 0) begin
            check($sformatf("clr_vld_b_%0d", i - 1), {31'd0, bus_b.rd_valid}, 32'd1);
            check($sformatf("clr_err_b_%0d", i - 1), {31'd0, bus_b.rd_err}, {31'd0, (i - 1) >= 20});
            check($sformatf("clr_data_b_%0d", i - 1), bus_b.rd_data, 32'd0);
         end
      end
      idle();
      tick();
      check("clr_tail_vld_a", {31'd0, bus_a.rd_valid}, 32'd0);
      check("clr_tail_vld_b", {31'd0, bus_b.rd_valid}, 32'd1);
      check("clr_tail_err_b", {31'd0, bus_b.rd_err}, 32'd1);
      tick();
      check("clr_idle_vld_b", {31'd0, bus_b.rd_valid}, 32'd0);
      check("clr_idle_err_b", {31'd0, bus_b.rd_err}, 32'd0);

      // Byte enables.
      wr(5'd3, 32'hDEAD_BEEF, 4'b1111);
      tick();
      wr(5'd3, 32'h0000_00AA, 4'b0001);
      tick();
      wr(5'd3, 32'hFFFF_FFFF, 4'b0000);
      tick();
      check("be0_werr_a", {31'd0, bus_a.wr_err}, 32'd0);
      idle();
      rd(5'd3);
      tick();
      check("be_vld_a", {31'd0, bus_a.rd_valid}, 32'd1);
      check("be_data_a", bus_a.rd_data, 32'hDEAD_BEAA);
      idle();
      tick();
      check("be_hold_vld_a", {31'd0, bus_a.rd_valid}, 32'd0);
      check("be_hold_data_a", bus_a.rd_data, 32'hDEAD_BEAA);
      check("be_vld_b", {31'd0, bus_b.rd_valid}, 32'd1);
      check("be_data_b", bus_b.rd_data, 32'hDEAD_BEAA);

      // Read-during-write to the same address.
      wr(5'd5, 32'h2222_2222, 4'hF);
      tick();
      wr(5'd5, 32'h1111_1111, 4'hF);
      rd(5'd5);
      tick();
      check("rdw_data_a", bus_a.rd_data, 32'h1111_1111);
      idle();
      tick();
      check("rdw_data_b", bus_b.rd_data, 32'h2222_2222);
      wr(5'd6, 32'h3333_3333, 4'hF);
      rd(5'd5);
      tick();
      check("rdw_diff_a", bus_a.rd_data, 32'h1111_1111);
      idle();
      tick();
      check("rdw_diff_b", bus_b.rd_data, 32'h1111_1111);
      wr(5'd5, 32'hAAAA_5555, 4'b0110);
      rd(5'd5);
      tick();
      check("rdw_part_a", bus_a.rd_data, 32'h11AA_5511);
      idle();
      tick();
      check("rdw_part_b", bus_b.rd_data, 32'h1111_1111);

      // Out-of-range on B (DEPTH=20); addr 25 is legal on A.
      wr(5'd25, 32'h1234_5678, 4'hF);
      tick();
      check("oor_werr_b", {31'd0, bus_b.wr_err}, 32'd1);
      check("oor_werr_a", {31'd0, bus_a.wr_err}, 32'd0);
      idle();
      tick();
      check("oor_werr_b_pulse", {31'd0, bus_b.wr_err}, 32'd0);
      rd(5'd25);
      tick();
      check("oor_data_a", bus_a.rd_data, 32'h1234_5678);
      check("oor_err_a", {31'd0, bus_a.rd_err}, 32'd0);
      rd(5'd5);
      tick();
      check("oor_vld_b", {31'd0, bus_b.rd_valid}, 32'd1);
      check("oor_err_b", {31'd0, bus_b.rd_err}, 32'd1);
      check("oor_data_b", bus_b.rd_data, 32'd0);
      rd(5'd9);
      tick();
      check("alias5_data_b", bus_b.rd_data, 32'h11AA_5511);
      check("alias5_err_b", {31'd0, bus_b.rd_err}, 32'd0);
      check("addr9_data_a", bus_a.rd_data, 32'd0);
      idle();
      tick();
      check("alias9_data_b", bus_b.rd_data, 32'd0);

      // Back-to-back reads.
      for (int i = 0; i < 8; i++) begin
         wr(i[4:0], 32'hB0B0_0000 + i, 4'hF);
         tick();
      end
      idle();
      for (int j = 0; j < 10; j++) begin
         if (j < 8) rd(j[4:0]);
         else rd_enb = 1'b0;
         tick();
         check($sformatf("b2b_vld_a_%0d", j), {31'd0, bus_a.rd_valid}, {31'd0, j < 8});
         if (j < 8) check($sformatf("b2b_data_a_%0d", j), bus_a.rd_data, 32'hB0B0_0000 + j);
         check($sformatf("b2b_vld_b_%0d", j), {31'd0, bus_b.rd_valid}, {31'd0, j >= 1 && j <= 8});
         if (j >= 1 && j <= 8) check($sformatf("b2b_data_b_%0d", j), bus_b.rd_data, 32'hB0B0_0000 + j - 1);
      end
      check("b2b_hold_b", bus_b.rd_data, 32'hB0B0_0007);

      // Write landing while a latency-2 read is in flight.
      rd(5'd7);
      tick();
      idle();
      wr(5'd7, 32'h7777_7777, 4'hF);
      tick();
      check("inflt_vld_b", {31'd0, bus_b.rd_valid}, 32'd1);
      check("inflt_data_b", bus_b.rd_data, 32'hB0B0_0007);
      idle();
      rd(5'd7);
      tick();
      check("inflt_new_a", bus_a.rd_data, 32'h7777_7777);
      idle();
      tick();
      check("inflt_new_b", bus_b.rd_data, 32'h7777_7777);

      // Reset with a read in flight, then reset again mid-sweep.
      rd(5'd0);
      tick();
      check("flush_pre_a", bus_a.rd_data, 32'hB0B0_0000);
      idle();
      rst = 1'b1;
      tick();
      check("flush_vld_b", {31'd0, bus_b.rd_valid}, 32'd0);
      check("flush_vld_a", {31'd0, bus_a.rd_valid}, 32'd0);
      check("flush_data_a", bus_a.rd_data, 32'd0);
      check("flush_data_b", bus_b.rd_data, 32'd0);
      rst = 1'b0;
      rd(5'd2);
      for (int k = 1; k <= 10; k++) begin
         tick();
         check($sformatf("mid_busy_a_%0d", k), {31'd0, bus_a.init_busy}, 32'd1);
         check($sformatf("mid_vld_b_%0d", k), {31'd0, bus_b.rd_valid}, 32'd0);
      end
      idle();
      rst = 1'b1;
      tick();
      check("mid_rst_busy_a", {31'd0, bus_a.init_busy}, 32'd1);
      rst = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         tick();
         check($sformatf("resweep_busy_a_%0d", k), {31'd0, bus_a.init_busy}, {31'd0, k < 32});
         check($sformatf("resweep_busy_b_%0d", k), {31'd0, bus_b.init_busy}, {31'd0, k < 20});
      end
      rd(5'd2);
      tick();
      check("resweep_vld_a", {31'd0, bus_a.rd_valid}, 32'd1);
      check("resweep_data_a", bus_a.rd_data, 32'd0);
      rd(5'd7);
      tick();
      check("resweep_data_a7", bus_a.rd_data, 32'd0);
      check("resweep_vld_b", {31'd0, bus_b.rd_valid}, 32'd1);
      check("resweep_data_b", bus_b.rd_data, 32'd0);
      idle();
      tick();
      check("resweep_data_b7", bus_b.rd_data, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
